// File: rtl/video_timing_pkg.sv
// Shared types and constants for the HDMI raster timing path: FSM states,
// standard mode presets and the hve_sync bit layout.
package video_timing_pkg;

    typedef enum logic [1:0] {StIdle, StRun, StDrain} vt_state_e;

    localparam int unsigned HVE_DE = 2;
    localparam int unsigned HVE_VS = 1;
    localparam int unsigned HVE_HS = 0;

    // 640x480 @ 60 Hz, 25.175 MHz pixel clock, negative syncs
    localparam int unsigned VGA_H_ACTIVE = 640;
    localparam int unsigned VGA_H_FP     = 16;
    localparam int unsigned VGA_H_SYNC   = 96;
    localparam int unsigned VGA_H_BP     = 48;
    localparam int unsigned VGA_V_ACTIVE = 480;
    localparam int unsigned VGA_V_FP     = 10;
    localparam int unsigned VGA_V_SYNC   = 2;
    localparam int unsigned VGA_V_BP     = 33;
    localparam bit          VGA_HS_POL   = 1'b0;
    localparam bit          VGA_VS_POL   = 1'b0;

    // 1280x720 @ 60 Hz, 74.25 MHz pixel clock, positive syncs
    localparam int unsigned HD_H_ACTIVE = 1280;
    localparam int unsigned HD_H_FP     = 110;
    localparam int unsigned HD_H_SYNC   = 40;
    localparam int unsigned HD_H_BP     = 220;
    localparam int unsigned HD_V_ACTIVE = 720;
    localparam int unsigned HD_V_FP     = 5;
    localparam int unsigned HD_V_SYNC   = 5;
    localparam int unsigned HD_V_BP     = 20;
    localparam bit          HD_HS_POL   = 1'b1;
    localparam bit          HD_VS_POL   = 1'b1;

    function automatic logic sync_level(input logic early, input logic pol);
        return early ^ ~pol;
    endfunction

endpackage

// File: rtl/video_delay_line.sv
// Fixed-depth shift register with synchronous reset to a parameter value;
// aligns early raster control with pixels returned by the source.
module video_delay_line #(
    parameter int unsigned       WIDTH   = 4,
    parameter int unsigned       DEPTH   = 2,
    parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= RST_VAL;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/video_timing_ctrl.sv
// Raster timing generator for the HDMI path: fetches pixels PIX_LAT cycles
// ahead and realigns returned data with delayed sync/DE.
module video_timing_ctrl
    import video_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0,
    parameter int unsigned PIX_LAT  = 2
) (
    input  logic        hdmi_clk,
    input  logic        reset,
    input  logic        enable,
    output logic        pix_req,
    output logic [10:0] pix_x,
    output logic [9:0]  pix_y,
    input  logic [23:0] pix_rgb,
    input  logic        pix_valid,
    output logic [2:0]  hve_sync,
    output logic [23:0] rgb,
    output logic        frame_start,
    output logic        underflow
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
    localparam logic [10:0] H_SS   = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] H_SE   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
    localparam logic [9:0]  V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0]  V_SS   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  V_SE   = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);

    vt_state_e   state_q;
    logic [10:0] h_cnt_q;
    logic [9:0]  v_cnt_q;
    logic [3:0]  early_q;  // {de, vs, hs, frame_start}, aligned with pix_req
    logic [3:0]  late;
    logic        underflow_q;

    logic running, de_early, hs_early, vs_early, fs_early, frame_end, starved;

    always_comb begin
        running   = (state_q != StIdle);
        de_early  = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
        hs_early  = (h_cnt_q >= H_SS) && (h_cnt_q < H_SE);
        vs_early  = (v_cnt_q >= V_SS) && (v_cnt_q < V_SE);
        fs_early  = (h_cnt_q == '0) && (v_cnt_q == '0);
        frame_end = (h_cnt_q == H_LAST) && (v_cnt_q == V_LAST);
    end

    always_ff @(posedge hdmi_clk) begin
        if (reset) begin
            state_q <= StIdle;
            h_cnt_q <= '0;
            v_cnt_q <= '0;
            early_q <= '0;
            pix_req <= 1'b0;
            pix_x   <= '0;
            pix_y   <= '0;
        end else begin
            early_q <= running ? {de_early, vs_early, hs_early, fs_early} : '0;
            pix_req <= running && de_early;
            pix_x   <= (running && de_early) ? h_cnt_q : '0;
            pix_y   <= (running && de_early) ? v_cnt_q : '0;
            case (state_q)
                StIdle: begin
                    h_cnt_q <= '0;
                    v_cnt_q <= '0;
                    if (enable) state_q <= StRun;
                end
                default: begin
                    if (h_cnt_q == H_LAST) begin
                        h_cnt_q <= '0;
                        v_cnt_q <= (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 10'd1;
                    end else begin
                        h_cnt_q <= h_cnt_q + 11'd1;
                    end
                    // Stopping only takes effect on the last cycle of a frame
                    if (enable)         state_q <= StRun;
                    else if (frame_end) state_q <= StIdle;
                    else                state_q <= StDrain;
                end
            endcase
        end
    end

    video_delay_line #(
        .WIDTH (4),
        .DEPTH (PIX_LAT)
    ) u_delay (
        .clk_i   (hdmi_clk),
        .reset_i (reset),
        .d_i     (early_q),
        .q_o     (late)
    );

    always_ff @(posedge hdmi_clk) begin
        if (reset) underflow_q <= 1'b0;
        else       underflow_q <= underflow_q | starved;
    end

    always_comb begin
        starved          = late[3] & ~pix_valid;
        hve_sync[HVE_DE] = late[3];
        hve_sync[HVE_VS] = sync_level(late[2], VS_POL);
        hve_sync[HVE_HS] = sync_level(late[1], HS_POL);
        frame_start      = late[0];
        rgb              = (late[3] && pix_valid) ? pix_rgb : 24'h0;
        underflow        = underflow_q | starved;
    end

endmodule
